// File: rtl/unit_b_sequencer_pkg.sv
// Shared types and derived constants for the unit-B layer sequencer.
package unit_b_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } seq_state_e;

    localparam int unsigned DEF_IFM_SIZE    = 32;
    localparam int unsigned DEF_KERNAL_SIZE = 5;

    localparam int unsigned KK       = DEF_KERNAL_SIZE * DEF_KERNAL_SIZE;
    localparam int unsigned PIXELS   = DEF_IFM_SIZE * DEF_IFM_SIZE;
    localparam int unsigned OUT_EDGE = DEF_IFM_SIZE - DEF_KERNAL_SIZE + 1;

    function automatic int unsigned calc_kk(input int unsigned kernel);
        return kernel * kernel;
    endfunction

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/unit_b_valid_pipe.sv
// Delay line carrying the window-valid mark and its depth tag alongside the convolution.
module unit_b_valid_pipe
    import unit_b_sequencer_pkg::*;
#(
    parameter int unsigned CONV_LATENCY = 2,
    parameter int unsigned TAG_W        = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned TAGS_W = CONV_LATENCY * TAG_W;

    logic [CONV_LATENCY-1:0] valid_q, valid_d;
    logic [TAGS_W-1:0]       tag_q, tag_d;

    // Stage 0 sits in the low bits; the cast drops the oldest entry.
    always_comb begin
        valid_d = CONV_LATENCY'({valid_q, in_valid});
        tag_d   = TAGS_W'({tag_q, in_tag});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid = valid_q[CONV_LATENCY-1];
    assign out_tag   = tag_q[TAGS_W-1 -: TAG_W];

endmodule

// File: rtl/unit_b_sequencer.sv
// Layer-pass sequencer: per filter/depth pair, load 25 weights, stream the IFM, drain the conv pipe.
module unit_b_sequencer
    import unit_b_sequencer_pkg::*;
#(
    parameter int unsigned IFM_SIZE          = DEF_IFM_SIZE,
    parameter int unsigned KERNAL_SIZE       = DEF_KERNAL_SIZE,
    parameter int unsigned NUMBER_OF_FILTERS = 6,
    parameter int unsigned DEPTH_PER_UNIT    = 2,
    parameter int unsigned CONV_LATENCY      = 2,
    parameter int unsigned ADDRESS_BITS      = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    ifm_valid,
    output logic                    ifm_fifo_enable,
    output logic                    wm_enable_read,
    output logic [ADDRESS_BITS-1:0] wm_address,
    output logic                    wm_fifo_enable,
    output logic                    conv_enable,
    output logic                    accu_enable,
    output logic                    relu_enable,
    output logic                    out_valid,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned L_KK  = calc_kk(KERNAL_SIZE);
    localparam int unsigned K_W   = cnt_w(L_KK + 1);
    localparam int unsigned POS_W = cnt_w(IFM_SIZE);
    localparam int unsigned DR_W  = cnt_w(CONV_LATENCY);
    localparam int unsigned F_W   = cnt_w(NUMBER_OF_FILTERS);
    localparam int unsigned D_W   = cnt_w(DEPTH_PER_UNIT);

    if (longint'(L_KK) * longint'(NUMBER_OF_FILTERS) * longint'(DEPTH_PER_UNIT)
        > (longint'(1) << ADDRESS_BITS)) begin : g_addr_range_check
        $error("unit_b_sequencer: weight address range exceeds ADDRESS_BITS");
    end
    if (CONV_LATENCY < 1) begin : g_latency_check
        $error("unit_b_sequencer: CONV_LATENCY must be at least 1");
    end

    seq_state_e              state_q, state_d;
    logic [K_W-1:0]          k_q, k_d;
    logic [POS_W-1:0]        row_q, row_d, col_q, col_d;
    logic [DR_W-1:0]         drain_q, drain_d;
    logic [F_W-1:0]          f_q, f_d;
    logic [D_W-1:0]          d_q, d_d;
    logic [ADDRESS_BITS-1:0] base_q, base_d;
    logic                    wm_fifo_enable_q, wm_fifo_enable_d;
    logic                    win_mark;
    logic                    pipe_valid;
    logic [D_W-1:0]          pipe_tag;

    always_comb begin
        state_d         = state_q;
        k_d             = k_q;
        row_d           = row_q;
        col_d           = col_q;
        drain_d         = drain_q;
        f_d             = f_q;
        d_d             = d_q;
        base_d          = base_q;
        wm_enable_read  = 1'b0;
        ifm_fifo_enable = 1'b0;
        conv_enable     = 1'b0;
        done            = 1'b0;
        win_mark        = 1'b0;
        busy            = (state_q != S_IDLE);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LOAD_W;
                    k_d     = '0;
                    row_d   = '0;
                    col_d   = '0;
                    drain_d = '0;
                    f_d     = '0;
                    d_d     = '0;
                    base_d  = '0;
                end
            end
            S_LOAD_W: begin
                // The final (KK-th) count is the read-latency slot with no strobe.
                if (k_q == K_W'(L_KK)) begin
                    k_d     = '0;
                    state_d = S_STREAM;
                end else begin
                    wm_enable_read = 1'b1;
                    k_d            = k_q + 1'b1;
                end
            end
            S_STREAM: begin
                ifm_fifo_enable = ifm_valid;
                conv_enable     = ifm_valid;
                if (ifm_valid) begin
                    win_mark = (row_q >= POS_W'(KERNAL_SIZE - 1)) &&
                               (col_q >= POS_W'(KERNAL_SIZE - 1));
                    if (col_q == POS_W'(IFM_SIZE - 1)) begin
                        col_d = '0;
                        if (row_q == POS_W'(IFM_SIZE - 1)) begin
                            row_d   = '0;
                            drain_d = '0;
                            state_d = S_DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (drain_q == DR_W'(CONV_LATENCY - 1)) begin
                    drain_d = '0;
                    base_d  = base_q + ADDRESS_BITS'(L_KK);
                    state_d = S_LOAD_W;
                    if (d_q == D_W'(DEPTH_PER_UNIT - 1)) begin
                        d_d = '0;
                        if (f_q == F_W'(NUMBER_OF_FILTERS - 1)) begin
                            f_d     = '0;
                            state_d = S_DONE;
                        end else begin
                            f_d = f_q + 1'b1;
                        end
                    end else begin
                        d_d = d_q + 1'b1;
                    end
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // base_q tracks (f*DEPTH_PER_UNIT+d)*KK incrementally across passes.
        wm_address       = wm_enable_read ? (base_q + ADDRESS_BITS'(k_q)) : '0;
        wm_fifo_enable_d = wm_enable_read;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= S_IDLE;
            k_q              <= '0;
            row_q            <= '0;
            col_q            <= '0;
            drain_q          <= '0;
            f_q              <= '0;
            d_q              <= '0;
            base_q           <= '0;
            wm_fifo_enable_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            k_q              <= k_d;
            row_q            <= row_d;
            col_q            <= col_d;
            drain_q          <= drain_d;
            f_q              <= f_d;
            d_q              <= d_d;
            base_q           <= base_d;
            wm_fifo_enable_q <= wm_fifo_enable_d;
        end
    end

    unit_b_valid_pipe #(
        .CONV_LATENCY (CONV_LATENCY),
        .TAG_W        (D_W)
    ) u_valid_pipe (
        .clk       (clk),
        .rst_n     (reset),
        .in_valid  (win_mark),
        .in_tag    (d_q),
        .out_valid (pipe_valid),
        .out_tag   (pipe_tag)
    );

    assign wm_fifo_enable = wm_fifo_enable_q;
    assign out_valid      = pipe_valid;
    assign accu_enable    = pipe_valid && (pipe_tag != '0);
    assign relu_enable    = pipe_valid && (pipe_tag == D_W'(DEPTH_PER_UNIT - 1));

endmodule

// File: tb/tb_unit_b_sequencer.sv
// Bench for unit_b_sequencer: a pass/pixel-count model checked every cycle, plus directed run statistics.
module tb_unit_b_sequencer;

    localparam int IFM   = 8;
    localparam int KS    = 5;
    localparam int NF    = 2;
    localparam int DEPTH = 2;
    localparam int LAT   = 2;
    localparam int AB    = 16;
    localparam int KKW   = KS * KS;
    localparam int PIX   = IFM * IFM;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          ifm_valid;
    logic          ifm_fifo_enable;
    logic          wm_enable_read;
    logic [AB-1:0] wm_address;
    logic          wm_fifo_enable;
    logic          conv_enable;
    logic          accu_enable;
    logic          relu_enable;
    logic          out_valid;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    unit_b_sequencer #(
        .IFM_SIZE          (IFM),
        .KERNAL_SIZE       (KS),
        .NUMBER_OF_FILTERS (NF),
        .DEPTH_PER_UNIT    (DEPTH),
        .CONV_LATENCY      (LAT),
        .ADDRESS_BITS      (AB)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .ifm_valid       (ifm_valid),
        .ifm_fifo_enable (ifm_fifo_enable),
        .wm_enable_read  (wm_enable_read),
        .wm_address      (wm_address),
        .wm_fifo_enable  (wm_fifo_enable),
        .conv_enable     (conv_enable),
        .accu_enable     (accu_enable),
        .relu_enable     (relu_enable),
        .out_valid       (out_valid),
        .busy            (busy),
        .done            (done)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: a run is NF*DEPTH passes; each pass is 26 load cycles, then PIX consumed
    // pixels, then LAT drain cycles. Window marks are scheduled LAT cycles ahead.
    bit m_active, m_done_now, prev_rd;
    int m_pass, m_pstart, m_pix, m_drain, start_cyc;
    int q_due[$];
    int q_tag[$];

    // DUT-side run statistics, cleared when the model accepts a start.
    int npass, ov_tot, relu_tot, done_cnt, done_lat;
    int first_addr[8], last_addr[8], rise_cyc[8], ov_pp[8], acc_pp[8];
    bit dut_rd_prev;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_stats();
        npass = 0; ov_tot = 0; relu_tot = 0; done_cnt = 0; done_lat = -1;
        for (int i = 0; i < 8; i++) begin
            first_addr[i] = -1; last_addr[i] = -1; rise_cyc[i] = 0;
            ov_pp[i] = 0; acc_pp[i] = 0;
        end
    endtask

    task automatic model_step();
        bit e_busy, e_done, e_ife, e_conv, e_rd, e_wfe, e_ov, e_acc, e_relu, accept;
        int u;
        logic [AB-1:0] e_addr;
        logic [8:0] e_flags, a_flags;
        e_busy = 0; e_done = 0; e_ife = 0; e_conv = 0; e_rd = 0; e_wfe = 0;
        e_ov = 0; e_acc = 0; e_relu = 0; accept = 0; e_addr = '0;
        if (!reset) begin
            m_active = 0; m_done_now = 0; prev_rd = 0;
            q_due.delete(); q_tag.delete();
        end else begin
            e_wfe = prev_rd;
            if (q_due.size() > 0 && q_due[0] == cyc) begin
                e_ov   = 1;
                e_acc  = (q_tag[0] > 0);
                e_relu = (q_tag[0] == DEPTH - 1);
                void'(q_due.pop_front());
                void'(q_tag.pop_front());
            end
            if (m_done_now) begin
                e_busy = 1; e_done = 1;
            end else if (m_active) begin
                e_busy = 1;
                u = cyc - m_pstart;
                if (u <= KKW) begin
                    e_rd = (u < KKW);
                    if (e_rd) e_addr = AB'(KKW * m_pass + u);
                end else if (m_pix < PIX) begin
                    e_ife = ifm_valid; e_conv = ifm_valid;
                    if (ifm_valid) begin
                        if ((m_pix / IFM) >= KS - 1 && (m_pix % IFM) >= KS - 1) begin
                            q_due.push_back(cyc + LAT);
                            q_tag.push_back(m_pass % DEPTH);
                        end
                        m_pix++;
                    end
                end else begin
                    m_drain++;
                end
            end else if (start) begin
                accept = 1;
            end
        end

        e_flags = {e_busy, e_done, e_ife, e_conv, e_rd, e_wfe, e_ov, e_acc, e_relu};
        a_flags = {busy, done, ifm_fifo_enable, conv_enable, wm_enable_read,
                   wm_fifo_enable, out_valid, accu_enable, relu_enable};
        chk("outputs{busy,done,ife,conv,rd,wfe,ov,acc,relu}", 32'(a_flags), 32'(e_flags));
        if (!reset || e_rd) chk("wm_address", 32'(wm_address), 32'(e_addr));

        if (reset) begin
            if (wm_enable_read && !dut_rd_prev) begin
                if (npass < 8) begin first_addr[npass] = int'(wm_address); rise_cyc[npass] = cyc; end
                npass++;
            end
            if (wm_enable_read && npass >= 1 && npass <= 8) last_addr[npass-1] = int'(wm_address);
            if (out_valid) begin
                ov_tot++;
                if (npass >= 1 && npass <= 8) ov_pp[npass-1]++;
            end
            if (accu_enable && npass >= 1 && npass <= 8) acc_pp[npass-1]++;
            if (relu_enable) relu_tot++;
            if (done) begin done_cnt++; done_lat = cyc - start_cyc; end
        end
        dut_rd_prev = reset ? wm_enable_read : 1'b0;

        if (reset) begin
            prev_rd = e_rd;
            if (m_done_now) begin
                m_done_now = 0;
            end else if (m_active && m_drain == LAT) begin
                m_pass++; m_drain = 0; m_pix = 0; m_pstart = cyc + 1;
                if (m_pass == NF * DEPTH) begin m_active = 0; m_done_now = 1; end
            end
            if (accept) begin
                m_active = 1; m_pass = 0; m_pix = 0; m_drain = 0;
                m_pstart = cyc + 1; start_cyc = cyc;
                clear_stats();
            end
        end
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_done(input int bound, input bit toggle);
        int n = 0;
        while (!done && n < bound) begin
            if (toggle) ifm_valid = ((cyc - start_cyc) % 2 == 0);
            tick();
            n++;
        end
        chk("done_within_bound", 32'(done), 32'd1);
    endtask

    task automatic check_four_passes(input string tag, input int period);
        chk({tag, "_passes"}, npass, NF * DEPTH);
        chk({tag, "_period"}, rise_cyc[1] - rise_cyc[0], period);
        chk({tag, "_ov_total"}, ov_tot, 64);
        for (int p = 0; p < 4; p++) chk({tag, "_ov_per_pass"}, ov_pp[p], 16);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; ifm_valid = 1'b0;
        m_active = 0; m_done_now = 0; prev_rd = 0; dut_rd_prev = 0; start_cyc = 0;
        m_pass = 0; m_pstart = 0; m_pix = 0; m_drain = 0;
        clear_stats();
        @(posedge clk); #1;
        repeat (3) tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_addr", 32'(wm_address), 32'd0);
        reset = 1'b1;
        repeat (3) tick();

        // Run A: ifm_valid held high, a stray start mid-run.
        ifm_valid = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        repeat (100) tick();
        start = 1'b1; repeat (3) tick(); start = 1'b0;
        run_until_done(400, 1'b0);
        start = 1'b1;
        tick();
        chk("a_done_count", done_cnt, 1);
        chk("a_done_latency", done_lat, 369);
        check_four_passes("a", 92);
        for (int p = 0; p < 4; p++) begin
            chk("a_first_addr", first_addr[p], 25 * p);
            chk("a_last_addr", last_addr[p], 25 * p + 24);
        end
        chk("a_accu_d0", acc_pp[0], 0);
        chk("a_accu_d1", acc_pp[1], 16);
        chk("a_relu_total", relu_tot, 32);
        chk("start_in_done_ignored", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        chk("start_after_done_taken", 32'(busy), 32'd1);

        // Run B: ifm_valid toggling, low on the first STREAM cycle.
        run_until_done(800, 1'b1);
        tick();
        ifm_valid = 1'b1;
        chk("b_done_latency", done_lat, 625);
        check_four_passes("b", 156);

        // Run C: reset pulse in the middle of pass 2 STREAM, then a fresh run.
        repeat (5) tick();
        start = 1'b1; tick(); start = 1'b0;
        begin
            int n = 0;
            while (npass < 2 && n < 300) begin tick(); n++; end
            chk("c_reached_pass2", npass, 2);
        end
        repeat (40) tick();
        reset = 1'b0;
        #1;
        chk("c_reset_busy", 32'(busy), 32'd0);
        chk("c_reset_conv", 32'(conv_enable), 32'd0);
        tick();
        reset = 1'b1;
        repeat (30) tick();
        chk("c_no_done_after_abort", done_cnt, 0);
        chk("c_idle_after_abort", 32'(busy), 32'd0);
        start = 1'b1; tick(); start = 1'b0;
        run_until_done(400, 1'b0);
        tick();
        chk("c_restart_addr", first_addr[0], 0);
        chk("c_done_latency", done_lat, 369);
        check_four_passes("c", 92);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
